// File: rtl/atom_ps2_keymatrix.sv
// PS/2 set-2 keyboard receiver feeding a 10x6 Acorn Atom key matrix plus SHIFT/CTRL/REPT lines.
// Optional build macro: PS2_PARITY_CHECK_EN (odd-parity check on every received frame).
module atom_ps2_keymatrix #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 32000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] key_row,
    output logic [5:0] key_cols,
    output logic       shift_n,
    output logic       ctrl_n,
    output logic       rept_n,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    // Scancode -> {hit, row[3:0], col[2:0]}; anything not listed has no Atom key.
    function automatic logic [7:0] map_key(input logic [7:0] code);
        logic [7:0] m;
        m = 8'h00;
        case (code)
            8'h76: m = {1'b1, 4'd0, 3'd5};  // ESC
            8'h15: m = {1'b1, 4'd0, 3'd4};  // Q
            8'h34: m = {1'b1, 4'd0, 3'd3};  // G
            8'h25: m = {1'b1, 4'd0, 3'd2};  // 4
            8'h26: m = {1'b1, 4'd0, 3'd1};  // 3
            8'h1A: m = {1'b1, 4'd1, 3'd5};  // Z
            8'h4D: m = {1'b1, 4'd1, 3'd4};  // P
            8'h2B: m = {1'b1, 4'd1, 3'd3};  // F
            8'h2E: m = {1'b1, 4'd1, 3'd2};  // 5
            8'h1E: m = {1'b1, 4'd1, 3'd1};  // 2
            8'h35: m = {1'b1, 4'd2, 3'd5};  // Y
            8'h44: m = {1'b1, 4'd2, 3'd4};  // O
            8'h24: m = {1'b1, 4'd2, 3'd3};  // E
            8'h36: m = {1'b1, 4'd2, 3'd2};  // 6
            8'h16: m = {1'b1, 4'd2, 3'd1};  // 1
            8'h1C: m = {1'b1, 4'd3, 3'd5};  // A
            8'h31: m = {1'b1, 4'd3, 3'd4};  // N
            8'h23: m = {1'b1, 4'd3, 3'd3};  // D
            8'h3D: m = {1'b1, 4'd3, 3'd2};  // 7
            8'h45: m = {1'b1, 4'd3, 3'd1};  // 0
            8'h22: m = {1'b1, 4'd4, 3'd5};  // X
            8'h3A: m = {1'b1, 4'd4, 3'd4};  // M
            8'h21: m = {1'b1, 4'd4, 3'd3};  // C
            8'h3E: m = {1'b1, 4'd4, 3'd2};  // 8
            8'h4C: m = {1'b1, 4'd4, 3'd1};  // ;
            8'h1D: m = {1'b1, 4'd5, 3'd5};  // W
            8'h4B: m = {1'b1, 4'd5, 3'd4};  // L
            8'h32: m = {1'b1, 4'd5, 3'd3};  // B
            8'h46: m = {1'b1, 4'd5, 3'd2};  // 9
            8'h55: m = {1'b1, 4'd5, 3'd1};  // =
            8'h2A: m = {1'b1, 4'd6, 3'd5};  // V
            8'h42: m = {1'b1, 4'd6, 3'd4};  // K
            8'h5B: m = {1'b1, 4'd6, 3'd3};  // ]
            8'h5A: m = {1'b1, 4'd6, 3'd1};  // RETURN
            8'h3C: m = {1'b1, 4'd7, 3'd5};  // U
            8'h3B: m = {1'b1, 4'd7, 3'd4};  // J
            8'h5D: m = {1'b1, 4'd7, 3'd3};  // backslash
            8'h66: m = {1'b1, 4'd7, 3'd1};  // DELETE
            8'h2C: m = {1'b1, 4'd8, 3'd5};  // T
            8'h43: m = {1'b1, 4'd8, 3'd4};  // I
            8'h54: m = {1'b1, 4'd8, 3'd3};  // [
            8'h0D: m = {1'b1, 4'd8, 3'd1};  // COPY (TAB)
            8'h1B: m = {1'b1, 4'd9, 3'd5};  // S
            8'h33: m = {1'b1, 4'd9, 3'd4};  // H
            8'h2D: m = {1'b1, 4'd9, 3'd3};  // R
            8'h29: m = {1'b1, 4'd9, 3'd0};  // SPACE
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    logic [1:0]     clk_sync_r;
    logic [1:0]     data_sync_r;
    logic           clk_level_r;
    logic [FCW-1:0] filt_cnt_r;
    logic           strobe_r;
    logic [TCW-1:0] to_cnt_r;
    state_e         state_r;
    state_e         state_nx;
    logic [2:0]     bit_cnt_r;
    logic [7:0]     sr_r;
    logic           frame_err_r;
    logic           byte_valid_s;
    logic           frame_err_s;
    logic           timeout_s;
    logic           stop_ok_s;
    logic           data_s;
    logic [7:0]     kmap_s;
    logic           brk_r;
    logic           ext_r;
    logic [9:0][5:0] mat_r;
    logic           lshift_r, rshift_r, lctrl_r, rctrl_r, lalt_r, ralt_r;

    assign data_s = data_sync_r[1];

    // Two-flop synchronisers for both PS/2 lines (idle level is high).
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // Glitch filter: the level flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_level_r <= 1'b1;
            filt_cnt_r  <= '0;
            strobe_r    <= 1'b0;
        end else if (clk_sync_r[1] == clk_level_r) begin
            filt_cnt_r <= '0;
            strobe_r   <= 1'b0;
        end else if (filt_cnt_r == FCW'(FILTER_LEN - 1)) begin
            clk_level_r <= clk_sync_r[1];
            filt_cnt_r  <= '0;
            strobe_r    <= clk_level_r;
        end else begin
            filt_cnt_r <= filt_cnt_r + FCW'(1);
            strobe_r   <= 1'b0;
        end
    end

    // Saturating inactivity counter, cleared by every bit strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_r <= '0;
        end else if (strobe_r) begin
            to_cnt_r <= '0;
        end else if (to_cnt_r != TCW'(TIMEOUT_CYCLES)) begin
            to_cnt_r <= to_cnt_r + TCW'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    assign timeout_s = (to_cnt_r == TCW'(TIMEOUT_CYCLES)) && (state_r != S_IDLE);

`ifdef PS2_PARITY_CHECK_EN
    logic par_ok_r;

    // Odd parity over data plus parity bit, latched as the parity bit arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_ok_r <= 1'b0;
        end else if (strobe_r && (state_r == S_PARITY)) begin
            par_ok_r <= ^{sr_r, data_s};
        end else begin
            par_ok_r <= par_ok_r;
        end
    end

    assign stop_ok_s = data_s & par_ok_r;
`else
    assign stop_ok_s = data_s;
`endif

    // Frame state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            frame_err_r <= frame_err_s;
        end
    end

    // Frame next-state, byte delivery and error decisions; a strobe outranks a timeout.
    always_comb begin
        state_nx     = state_r;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        if (strobe_r) begin
            case (state_r)
                S_IDLE: begin
                    if (!data_s) begin
                        state_nx = S_DATA;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
                S_DATA: begin
                    if (bit_cnt_r == 3'd7) begin
                        state_nx = S_PARITY;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
                S_PARITY: state_nx = S_STOP;
                S_STOP: begin
                    state_nx = S_IDLE;
                    if (stop_ok_s) begin
                        byte_valid_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end else if (timeout_s) begin
            state_nx    = S_IDLE;
            frame_err_s = 1'b1;
        end else begin
            state_nx = state_r;
        end
    end

    // Data shifter, LSB first.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_r      <= 8'h00;
            bit_cnt_r <= 3'd0;
        end else if (strobe_r && (state_r == S_DATA)) begin
            sr_r      <= {data_s, sr_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end else if (strobe_r && (state_r == S_IDLE)) begin
            bit_cnt_r <= 3'd0;
        end else begin
            sr_r      <= sr_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    assign kmap_s = map_key(sr_r);

    // Scancode decoder: prefix flags, modifiers and the key matrix.
    always_ff @(posedge clk) begin
        if (reset) begin
            brk_r    <= 1'b0;
            ext_r    <= 1'b0;
            mat_r    <= '0;
            lshift_r <= 1'b0;
            rshift_r <= 1'b0;
            lctrl_r  <= 1'b0;
            rctrl_r  <= 1'b0;
            lalt_r   <= 1'b0;
            ralt_r   <= 1'b0;
        end else if (byte_valid_s) begin
            case (sr_r)
                8'hF0: brk_r <= 1'b1;
                8'hE0: ext_r <= 1'b1;
                8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                    brk_r <= brk_r;
                end
                default: begin
                    brk_r <= 1'b0;
                    ext_r <= 1'b0;
                    if (ext_r) begin
                        case (sr_r)
                            8'h14:   rctrl_r <= ~brk_r;
                            8'h11:   ralt_r  <= ~brk_r;
                            default: rctrl_r <= rctrl_r;
                        endcase
                    end else begin
                        case (sr_r)
                            8'h12: lshift_r <= ~brk_r;
                            8'h59: rshift_r <= ~brk_r;
                            8'h14: lctrl_r  <= ~brk_r;
                            8'h11: lalt_r   <= ~brk_r;
                            default: begin
                                if (kmap_s[7]) begin
                                    mat_r[kmap_s[6:3]][kmap_s[2:0]] <= ~brk_r;
                                end else begin
                                    mat_r <= mat_r;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end else begin
            brk_r <= brk_r;
        end
    end

    // Zero-latency row read for the PIO.
    always_comb begin
        key_cols = 6'h3F;
        if (key_row <= 4'd9) begin
            key_cols = ~mat_r[key_row];
        end else begin
            key_cols = 6'h3F;
        end
    end

    assign shift_n   = ~(lshift_r | rshift_r);
    assign ctrl_n    = ~(lctrl_r | rctrl_r);
    assign rept_n    = ~(lalt_r | ralt_r);
    assign frame_err = frame_err_r;

endmodule
